// File: rtl/fp_addsub_pipe.sv
// fp_addsub_pipe: parametrised IEEE-754-style add/subtract, y = a +/- b.
//
// Round-to-nearest-even (or truncate) using guard/round/sticky bits. Subnormal inputs are
// flushed to signed zero and subnormal results flush to zero with underflow. Inf and NaN are
// handled, and the unit raises exception flags. The default parameters give binary32.
//
// Pipeline: an operand capture register, then three processing ranks:
// S1 unpack/align, S2 magnitude add/subtract, S3 normalise/round/pack.
// An operand accepted at edge N gives out_valid high after edge N+3. All ranks move together
// on en = out_ready_i | ~out_valid_o. When en is low, every rank holds, bubbles included.
//
// Ports (W = 1 + EXP_W + MAN_W):
//   clk          clock, rising edge
//   rst_n        asynchronous active-low reset; in-flight beats are dropped
//   in_valid_i   operand beat valid
//   in_ready_o   beat accepted this cycle when in_valid_i is also high
//   op_sub_i     1: y = a - b, 0: y = a + b
//   a_i, b_i     operands {sign, exp, frac}
//   out_valid_o  result valid
//   out_ready_i  consumer accepts the result
//   y_o          result
//   flags_o      {invalid, overflow, underflow, inexact}; qualified by out_valid_o
module fp_addsub_pipe #(
  parameter int unsigned EXP_W   = 8,
  parameter int unsigned MAN_W   = 23,
  parameter int unsigned RND_RNE = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic                   op_sub_i,
  input  logic [EXP_W+MAN_W:0]   a_i,
  input  logic [EXP_W+MAN_W:0]   b_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [EXP_W+MAN_W:0]   y_o,
  output logic [3:0]             flags_o
);

  localparam int unsigned W    = 1 + EXP_W + MAN_W;
  // Working mantissa: {carry, hidden, frac, guard, round, sticky}
  localparam int unsigned MW   = MAN_W + 5;
  localparam int unsigned LZ_W = $clog2(MW);
  // Exponent arithmetic width; the top bit acts as a sign for results below zero
  localparam int unsigned XW   = EXP_W + 2;
  localparam int unsigned MR_W = MAN_W + 2;
  localparam bit          RNE  = (RND_RNE != 0);

  localparam logic [EXP_W-1:0] EXP_ONES = {EXP_W{1'b1}};
  localparam logic [EXP_W-1:0] EXP_MAXF = EXP_ONES - 1'b1;
  localparam logic [EXP_W-1:0] SH_LIM   = EXP_W'(MAN_W + 3);
  localparam logic [W-1:0]     QNAN     = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};

  logic en;

  // ------------------------------------------------------------------------------------------
  // Operand capture; the sign of b is inverted here for subtraction
  // ------------------------------------------------------------------------------------------
  logic         v0_q;
  logic [W-1:0] a0_q, b0_q;

  assign en         = out_ready_i | ~out_valid_o;
  assign in_ready_o = en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v0_q <= 1'b0;
      a0_q <= '0;
      b0_q <= '0;
    end else if (en) begin
      v0_q <= in_valid_i;
      a0_q <= a_i;
      b0_q <= {b_i[W-1] ^ op_sub_i, b_i[W-2:0]};
    end
  end

  // ------------------------------------------------------------------------------------------
  // S1: unpack, classify, order by magnitude, align the smaller operand
  // ------------------------------------------------------------------------------------------
  logic             sa, sb;
  logic [EXP_W-1:0] ea, eb;
  logic [MAN_W-1:0] fa, fb;
  logic             za, zb, all1_a, all1_b;
  logic             inf_a, inf_b, nan_a, nan_b, snan_a, snan_b;
  logic [W-2:0]     key_a, key_b;
  logic             swap;
  logic             sgn_big, z_big, z_small;
  logic [EXP_W-1:0] e_big, e_small, d_s1;
  logic [MAN_W-1:0] f_big, f_small;
  logic [MW-1:0]    m_big, m_small_raw, m_small_al;
  logic             lost;
  logic             spec_d;
  logic [W-1:0]     spec_y_d;
  logic [3:0]       spec_fl_d;

  assign sa = a0_q[W-1];
  assign sb = b0_q[W-1];
  assign ea = a0_q[W-2:MAN_W];
  assign eb = b0_q[W-2:MAN_W];
  assign fa = a0_q[MAN_W-1:0];
  assign fb = b0_q[MAN_W-1:0];

  assign za     = (ea == '0);
  assign zb     = (eb == '0);
  assign all1_a = (ea == EXP_ONES);
  assign all1_b = (eb == EXP_ONES);
  assign inf_a  = all1_a & (fa == '0);
  assign inf_b  = all1_b & (fb == '0);
  assign nan_a  = all1_a & (fa != '0);
  assign nan_b  = all1_b & (fb != '0);
  assign snan_a = nan_a & ~fa[MAN_W-1];
  assign snan_b = nan_b & ~fb[MAN_W-1];

  // Flushed operands compare as zero regardless of their fraction bits
  assign key_a = za ? '0 : {ea, fa};
  assign key_b = zb ? '0 : {eb, fb};
  assign swap  = (key_b > key_a);

  always_comb begin
    sgn_big    = swap ? sb : sa;
    z_big      = swap ? zb : za;
    z_small    = swap ? za : zb;
    e_big      = swap ? eb : ea;
    e_small    = swap ? ea : eb;
    f_big      = swap ? fb : fa;
    f_small    = swap ? fa : fb;
    m_big       = {1'b0, ~z_big, z_big ? '0 : f_big, 3'b000};
    m_small_raw = {1'b0, ~z_small, z_small ? '0 : f_small, 3'b000};
    d_s1       = e_big - e_small;
    lost       = 1'b0;
    m_small_al = '0;
    if (z_small) begin
      m_small_al = '0;
    end else if (d_s1 >= SH_LIM) begin
      // Aligned entirely below the round bit: only the sticky survives
      m_small_al = {{(MW-1){1'b0}}, 1'b1};
    end else begin
      lost       = |(m_small_raw & ~({MW{1'b1}} << d_s1));
      m_small_al = (m_small_raw >> d_s1) | {{(MW-1){1'b0}}, lost};
    end
  end

  // Special operands bypass the datapath; NaN outranks Inf - Inf, which outranks plain Inf
  always_comb begin
    spec_d    = nan_a | nan_b | inf_a | inf_b;
    spec_y_d  = '0;
    spec_fl_d = '0;
    if (nan_a || nan_b) begin
      spec_y_d  = QNAN;
      spec_fl_d = {snan_a | snan_b, 3'b000};
    end else if (inf_a && inf_b && (sa != sb)) begin
      spec_y_d  = QNAN;
      spec_fl_d = 4'b1000;
    end else if (inf_a) begin
      spec_y_d = a0_q;
    end else if (inf_b) begin
      spec_y_d = b0_q;
    end
  end

  logic             v1_q, spec1_q, sgn1_q, sub1_q, bz1_q, zs1_q;
  logic [W-1:0]     spy1_q;
  logic [3:0]       spf1_q;
  logic [EXP_W-1:0] exp1_q;
  logic [MW-1:0]    mb1_q, ms1_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q    <= 1'b0;
      spec1_q <= 1'b0;
      spy1_q  <= '0;
      spf1_q  <= '0;
      sgn1_q  <= 1'b0;
      sub1_q  <= 1'b0;
      exp1_q  <= '0;
      mb1_q   <= '0;
      ms1_q   <= '0;
      bz1_q   <= 1'b0;
      zs1_q   <= 1'b0;
    end else if (en) begin
      v1_q    <= v0_q;
      spec1_q <= spec_d;
      spy1_q  <= spec_y_d;
      spf1_q  <= spec_fl_d;
      sgn1_q  <= sgn_big;
      sub1_q  <= sa ^ sb;
      exp1_q  <= e_big;
      mb1_q   <= m_big;
      ms1_q   <= m_small_al;
      bz1_q   <= za & zb;
      zs1_q   <= sa & sb;
    end
  end

  // ------------------------------------------------------------------------------------------
  // S2: magnitude add/subtract; |big| >= |small| keeps the difference non-negative
  // ------------------------------------------------------------------------------------------
  logic [MW-1:0] sum_d;

  assign sum_d = sub1_q ? (mb1_q - ms1_q) : (mb1_q + ms1_q);

  logic             v2_q, spec2_q, sgn2_q, bz2_q, zs2_q;
  logic [W-1:0]     spy2_q;
  logic [3:0]       spf2_q;
  logic [EXP_W-1:0] exp2_q;
  logic [MW-1:0]    sum2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2_q    <= 1'b0;
      spec2_q <= 1'b0;
      spy2_q  <= '0;
      spf2_q  <= '0;
      sgn2_q  <= 1'b0;
      exp2_q  <= '0;
      sum2_q  <= '0;
      bz2_q   <= 1'b0;
      zs2_q   <= 1'b0;
    end else if (en) begin
      v2_q    <= v1_q;
      spec2_q <= spec1_q;
      spy2_q  <= spy1_q;
      spf2_q  <= spf1_q;
      sgn2_q  <= sgn1_q;
      exp2_q  <= exp1_q;
      sum2_q  <= sum_d;
      bz2_q   <= bz1_q;
      zs2_q   <= zs1_q;
    end
  end

  // ------------------------------------------------------------------------------------------
  // S3: normalise, round, detect over/underflow, pack
  // ------------------------------------------------------------------------------------------
  logic [LZ_W-1:0]  lz;
  logic [XW-1:0]    exp_x, exp_n, exp_f;
  logic [MW-2:0]    norm;
  logic             g, r, s, lsb, inc, inexact;
  logic [MR_W-1:0]  mant_r;
  logic [MAN_W-1:0] frac_f;
  logic             ovf, unf;
  logic [W-1:0]     y_d;
  logic [3:0]       fl_d;

  always_comb begin
    // Leading zeros counted from the hidden-bit position; the highest set bit wins
    lz = '0;
    for (int i = 0; i < int'(MW) - 1; i++) begin
      if (sum2_q[i]) lz = LZ_W'(int'(MW) - 2 - i);
    end
    exp_x = XW'(exp2_q);
    if (sum2_q[MW-1]) begin
      norm    = sum2_q[MW-1:1];
      norm[0] = sum2_q[1] | sum2_q[0];
      exp_n   = exp_x + XW'(1);
    end else begin
      norm  = sum2_q[MW-2:0] << lz;
      exp_n = exp_x - XW'(lz);
    end
    g       = norm[2];
    r       = norm[1];
    s       = norm[0];
    lsb     = norm[3];
    inc     = RNE & g & (r | s | lsb);
    inexact = g | r | s;
    mant_r  = {1'b0, norm[MW-2:3]} + MR_W'(inc);
    if (mant_r[MAN_W+1]) begin
      frac_f = mant_r[MAN_W:1];
      exp_f  = exp_n + XW'(1);
    end else begin
      frac_f = mant_r[MAN_W-1:0];
      exp_f  = exp_n;
    end
    ovf = ~exp_f[XW-1] & (exp_f >= XW'(EXP_ONES));
    unf = exp_f[XW-1] | (exp_f == '0);

    y_d  = '0;
    fl_d = '0;
    if (spec2_q) begin
      y_d  = spy2_q;
      fl_d = spf2_q;
    end else if (sum2_q == '0) begin
      // Exact cancellation is +0; only a sum of two zeros keeps a negative sign
      y_d = {bz2_q & zs2_q, {(W-1){1'b0}}};
    end else if (ovf) begin
      y_d  = RNE ? {sgn2_q, EXP_ONES, {MAN_W{1'b0}}} : {sgn2_q, EXP_MAXF, {MAN_W{1'b1}}};
      fl_d = 4'b0101;
    end else if (unf) begin
      y_d  = {sgn2_q, {(W-1){1'b0}}};
      fl_d = 4'b0011;
    end else begin
      y_d  = {sgn2_q, exp_f[EXP_W-1:0], frac_f};
      fl_d = {3'b000, inexact};
    end
  end

  logic         out_valid_q;
  logic [W-1:0] y_q;
  logic [3:0]   flags_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      y_q         <= '0;
      flags_q     <= '0;
    end else if (en) begin
      out_valid_q <= v2_q;
      if (v2_q) begin
        y_q     <= y_d;
        flags_q <= fl_d;
      end
    end
  end

  assign out_valid_o = out_valid_q;
  assign y_o         = y_q;
  assign flags_o     = flags_q;

endmodule

// File: tb/tb_fp_addsub_pipe.sv
// tb_fp_addsub_pipe: directed bench for fp_addsub_pipe at binary32 defaults.
// Inputs are driven and outputs sampled 1-2 time units after the rising edge.
module tb_fp_addsub_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid, in_ready, op_sub, out_valid, out_ready;
  logic [31:0] a, b, y;
  logic [3:0]  flags;

  int checks = 0;
  int errors = 0;

  fp_addsub_pipe dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .op_sub_i    (op_sub),
    .a_i         (a),
    .b_i         (b),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .y_o         (y),
    .flags_o     (flags)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called just after a rising edge with out_ready high and the pipeline empty.
  task automatic run_vec(input string tag, input logic [31:0] va, input logic [31:0] vb,
                         input logic sub, input logic [31:0] ey, input logic [3:0] ef);
    int lat;
    in_valid = 1'b1;
    a        = va;
    b        = vb;
    op_sub   = sub;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, " latency"}, 32'(lat), 32'd3);
    check({tag, " y"}, y, ey);
    check({tag, " flags"}, {28'd0, flags}, {28'd0, ef});
  endtask

  logic [31:0] s_a [8];
  logic [31:0] s_y [8];
  int tx, rx, extra, stale;

  initial begin
    s_a = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
            32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000};
    s_y = '{32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000,
            32'h40C00000, 32'h40E00000, 32'h41000000, 32'h41100000};

    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    op_sub    = 1'b0;
    out_ready = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    check("reset out_valid", {31'd0, out_valid}, 32'd0);
    check("reset y", y, 32'h0);
    check("reset flags", {28'd0, flags}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post-reset in_ready", {31'd0, in_ready}, 32'd1);

    // Directed vectors: {invalid, overflow, underflow, inexact}
    run_vec("1+1",          32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 4'b0000);
    run_vec("tie even",     32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 4'b0001);
    run_vec("above tie",    32'h3F800000, 32'h33800001, 1'b0, 32'h3F800001, 4'b0001);
    run_vec("round carry",  32'h3F7FFFFF, 32'h33000000, 1'b0, 32'h3F800000, 4'b0001);
    run_vec("x-x",          32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 4'b0000);
    run_vec("2-1",          32'h40000000, 32'h3F800000, 1'b1, 32'h3F800000, 4'b0000);
    run_vec("1-2",          32'h3F800000, 32'h40000000, 1'b1, 32'hBF800000, 4'b0000);
    run_vec("inf-inf",      32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 4'b1000);
    run_vec("snan+0",       32'h7F800001, 32'h00000000, 1'b0, 32'h7FC00000, 4'b1000);
    run_vec("qnan+1",       32'h7FC00001, 32'h3F800000, 1'b0, 32'h7FC00000, 4'b0000);
    run_vec("inf+1",        32'h7F800000, 32'h3F800000, 1'b0, 32'h7F800000, 4'b0000);
    run_vec("1-inf",        32'h3F800000, 32'h7F800000, 1'b1, 32'hFF800000, 4'b0000);
    run_vec("max+max",      32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 4'b0101);
    run_vec("tiny diff",    32'h00800001, 32'h00800000, 1'b1, 32'h00000000, 4'b0011);
    run_vec("-0+-0",        32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 4'b0000);
    run_vec("+0+-0",        32'h00000000, 32'h80000000, 1'b0, 32'h00000000, 4'b0000);
    run_vec("subnorm+1",    32'h00000001, 32'h3F800000, 1'b0, 32'h3F800000, 4'b0000);

    // Drain, then stream 8 beats with out_ready low on cycles 4-6
    repeat (4) begin @(posedge clk); #1; end
    tx = 0;
    rx = 0;
    for (int c = 0; c < 40 && rx < 8; c++) begin
      out_ready = !(c >= 4 && c <= 6);
      in_valid  = (tx < 8);
      a         = (tx < 8) ? s_a[tx] : 32'h0;
      b         = 32'h3F800000;
      op_sub    = 1'b0;
      #1;
      if (!out_ready) begin
        check($sformatf("stall c%0d in_ready", c), {31'd0, in_ready}, 32'd0);
        check($sformatf("stall c%0d out_valid", c), {31'd0, out_valid}, 32'd1);
        check($sformatf("stall c%0d y held", c), y, s_y[rx]);
      end
      if (in_valid && in_ready) tx++;
      if (out_valid && out_ready) begin
        check($sformatf("stream y%0d", rx), y, s_y[rx]);
        rx++;
      end
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check("stream accepted", 32'(tx), 32'd8);
    check("stream received", 32'(rx), 32'd8);
    extra = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (out_valid) extra++;
    end
    check("stream no duplicate", 32'(extra), 32'd0);

    // Reset with three beats in flight, one already at the output
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      a        = s_a[i];
      b        = 32'h3F800000;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("pre-reset out_valid", {31'd0, out_valid}, 32'd1);
    check("pre-reset y", y, s_y[0]);
    #2 rst_n = 1'b0;
    #1;
    check("async reset out_valid", {31'd0, out_valid}, 32'd0);
    check("async reset y", y, 32'h0);
    check("async reset flags", {28'd0, flags}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    stale = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (out_valid) stale++;
    end
    check("no stale after reset", 32'(stale), 32'd0);
    check("in_ready after reset", {31'd0, in_ready}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
